dram_read_master: RTL and testbench

AXI4 read master that serves the image sender's DRAM read-request port. It accepts a single request (`dram_read_en`, `dram_read_addr`, `dram_read_len`), splits it into AXI4 INCR bursts that never cross a 4 KB boundary, and returns each data beat as a one-cycle `dram_read_data_valid` pulse. It sits between the image sender and the PS/DDR AXI HP port, in the `clk_pixel` domain.

---
 rtl/dram_read_master_if.sv | 29 ++
 rtl/dram_read_master.sv | 145 ++++++++++++++
 tb/tb_dram_read_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_read_master_if.sv
// AXI4 read-address and read-data channels between dram_read_master and the
// DDR HP port. The master modport is the read master's view of the bus.
interface dram_read_master_if #(
    parameter int unsigned DRAM_ADDR_WIDTH = 39,
    parameter int unsigned DRAM_DATA_WIDTH = 512
);
    logic [DRAM_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                 arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic [3:0]                 arcache;
    logic                       arvalid;
    logic                       arready;
    logic [DRAM_DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/dram_read_master.sv
// AXI4 read master for the image sender. One request (start address, beat
// count) is split into INCR bursts that never cross a BOUNDARY_BYTES line.
// Only one AR is outstanding at a time. Each returned beat is presented as a
// one-cycle dram_read_data_valid pulse. Completion counts beats and does not
// rely on rlast; any bad rresp or misplaced rlast sets a sticky error flag.
module dram_read_master #(
    parameter int unsigned DRAM_ADDR_WIDTH = 39,
    parameter int unsigned DRAM_DATA_WIDTH = 512,
    parameter int unsigned BOUNDARY_BYTES  = 4096
) (
    input  logic                       clk_pixel,
    input  logic                       dram_reader_resetn,
    input  logic                       dram_read_en,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic [7:0]                 dram_read_len,
    output logic                       dram_read_busy,
    output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic                       dram_read_data_valid,
    output logic                       dram_read_error,
    dram_read_master_if.master         m_axi
);

    localparam int unsigned BEAT_BYTES     = DRAM_DATA_WIDTH / 8;
    localparam int unsigned BEAT_SHIFT     = $clog2(BEAT_BYTES);
    localparam int unsigned BOUNDARY_SHIFT = $clog2(BOUNDARY_BYTES);
    localparam int unsigned BOUNDARY_BEATS = BOUNDARY_BYTES / BEAT_BYTES;
    localparam int unsigned OFFS_W         = BOUNDARY_SHIFT - BEAT_SHIFT;
    localparam logic [DRAM_ADDR_WIDTH-1:0] BEAT_MASK = DRAM_ADDR_WIDTH'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    // Beats in the next burst: what is left, capped at the distance to the
    // next boundary (offs is the beat index within the current boundary line).
    function automatic logic [8:0] sub_beats(input logic [OFFS_W-1:0] offs,
                                             input logic [8:0] remaining);
        int unsigned to_boundary;
        to_boundary = BOUNDARY_BEATS - 32'(offs);
        return (32'(remaining) < to_boundary) ? remaining : 9'(to_boundary);
    endfunction

    state_e                     state_q;
    logic [DRAM_ADDR_WIDTH-1:0] addr_q;
    logic [8:0]                 remaining_q;
    logic [8:0]                 beat_cnt_q;
    logic [7:0]                 arlen_q;
    logic                       arvalid_q;
    logic                       rready_q;
    logic                       busy_q;
    logic [DRAM_DATA_WIDTH-1:0] data_q;
    logic                       valid_q;
    logic                       error_q;

    logic [DRAM_ADDR_WIDTH-1:0] req_addr;
    logic [8:0]                 req_rem;
    logic [8:0]                 req_sub;
    logic [8:0]                 cur_sub;
    logic [DRAM_ADDR_WIDTH-1:0] next_addr;
    logic                       last_beat;

    // Request decode and burst sizing for the address currently held.
    assign req_addr  = dram_read_addr & ~BEAT_MASK;
    assign req_rem   = {1'b0, dram_read_len} + 9'd1;
    assign req_sub   = sub_beats(req_addr[BOUNDARY_SHIFT-1:BEAT_SHIFT], req_rem);
    assign cur_sub   = sub_beats(addr_q[BOUNDARY_SHIFT-1:BEAT_SHIFT], remaining_q);
    assign next_addr = addr_q + (DRAM_ADDR_WIDTH'(cur_sub) << BEAT_SHIFT);
    assign last_beat = (beat_cnt_q == 9'd1);

    // Request FSM; all outputs are registered here.
    always_ff @(posedge clk_pixel or negedge dram_reader_resetn) begin
        if (!dram_reader_resetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (dram_read_en) begin
                        addr_q      <= req_addr;
                        remaining_q <= req_rem;
                        arlen_q     <= 8'(req_sub - 9'd1);
                        arvalid_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StAddr;
                    end
                end
                StAddr: begin
                    if (m_axi.arready) begin
                        addr_q      <= next_addr;
                        remaining_q <= remaining_q - cur_sub;
                        beat_cnt_q  <= cur_sub;
                        arvalid_q   <= 1'b0;
                        rready_q    <= 1'b1;
                        state_q     <= StData;
                    end
                end
                StData: begin
                    if (m_axi.rvalid) begin
                        data_q     <= m_axi.rdata;
                        valid_q    <= 1'b1;
                        beat_cnt_q <= beat_cnt_q - 9'd1;
                        if ((m_axi.rresp != 2'b00) || (m_axi.rlast != last_beat)) begin
                            error_q <= 1'b1;
                        end
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            // addr_q/remaining_q already point past this burst.
                            if (remaining_q != 9'd0) begin
                                arlen_q   <= 8'(cur_sub - 9'd1);
                                arvalid_q <= 1'b1;
                                state_q   <= StAddr;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = 3'(BEAT_SHIFT);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign dram_read_busy       = busy_q;
    assign dram_read_data       = data_q;
    assign dram_read_data_valid = valid_q;
    assign dram_read_error      = error_q;

endmodule

// File: tb/tb_dram_read_master.sv
// Directed bench for dram_read_master: a table of requests with the expected
// AR sequence, driven through a scripted AXI slave, plus a mid-burst reset.
module tb_dram_read_master;

    localparam int unsigned AW = 39;
    localparam int unsigned DW = 512;

    logic          clk_pixel = 1'b0;
    logic          dram_reader_resetn;
    logic          dram_read_en;
    logic [AW-1:0] dram_read_addr;
    logic [7:0]    dram_read_len;
    logic          dram_read_busy;
    logic [DW-1:0] dram_read_data;
    logic          dram_read_data_valid;
    logic          dram_read_error;

    dram_read_master_if #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) axi ();

    dram_read_master #(
        .DRAM_ADDR_WIDTH(AW),
        .DRAM_DATA_WIDTH(DW),
        .BOUNDARY_BYTES (4096)
    ) dut (
        .clk_pixel           (clk_pixel),
        .dram_reader_resetn  (dram_reader_resetn),
        .dram_read_en        (dram_read_en),
        .dram_read_addr      (dram_read_addr),
        .dram_read_len       (dram_read_len),
        .dram_read_busy      (dram_read_busy),
        .dram_read_data      (dram_read_data),
        .dram_read_data_valid(dram_read_data_valid),
        .dram_read_error     (dram_read_error),
        .m_axi               (axi)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct packed {
        logic                rst_before;
        logic [AW-1:0]       addr;
        logic [7:0]          len;
        logic [2:0]          n_ar;
        logic [3:0][AW-1:0]  ar_addr;
        logic [3:0][7:0]     ar_len;
        logic [3:0]          ar_delay;
        logic [1:0]          gap;
        logic                mid_en;
        logic [1:0]          bad_kind;   // 1: rresp error, 2: early rlast
        logic [8:0]          bad_beat;
        logic                exp_err;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic rb, input logic [AW-1:0] a, input logic [7:0] l,
                                input int n,
                                input logic [AW-1:0] a0, input logic [7:0] l0,
                                input logic [AW-1:0] a1, input logic [7:0] l1,
                                input logic [AW-1:0] a2, input logic [7:0] l2,
                                input logic [AW-1:0] a3, input logic [7:0] l3,
                                input int dly, input int gp, input logic me,
                                input int bk, input int bb, input logic ee);
        vec_t v;
        v.rst_before = rb;
        v.addr       = a;
        v.len        = l;
        v.n_ar       = 3'(n);
        v.ar_addr[0] = a0; v.ar_len[0] = l0;
        v.ar_addr[1] = a1; v.ar_len[1] = l1;
        v.ar_addr[2] = a2; v.ar_len[2] = l2;
        v.ar_addr[3] = a3; v.ar_len[3] = l3;
        v.ar_delay   = 4'(dly);
        v.gap        = 2'(gp);
        v.mid_en     = me;
        v.bad_kind   = 2'(bk);
        v.bad_beat   = 9'(bb);
        v.exp_err    = ee;
        return v;
    endfunction

    function automatic logic [DW-1:0] pat(input int vi, input int k);
        logic [31:0] w;
        w = 32'hA500_0000 | (32'(vi) << 16) | 32'(k);
        return {16{w}};
    endfunction

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_reset();
        dram_reader_resetn = 1'b0;
        step();
        step();
        dram_reader_resetn = 1'b1;
        step();
    endtask

    task automatic wait_ar();
        int n = 0;
        while (!axi.arvalid && n < 16) begin
            step();
            n++;
        end
        if (!axi.arvalid) begin
            n_vec++;
            n_fail++;
            $display("FAIL ar_timeout: arvalid still 0 after 16 cycles");
            finish_run();
        end
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int k = 0;
        int total;
        total = int'(v.len) + 1;
        if (v.rst_before) do_reset();
        dram_read_en   = 1'b1;
        dram_read_addr = v.addr;
        dram_read_len  = v.len;
        step();
        dram_read_en = 1'b0;
        chk("busy_accept", 64'(dram_read_busy), 64'(1));
        chk("arvalid_accept", 64'(axi.arvalid), 64'(1));
        for (int s = 0; s < int'(v.n_ar); s++) begin
            wait_ar();
            chk("araddr", 64'(axi.araddr), 64'(v.ar_addr[s]));
            chk("arlen", 64'(axi.arlen), 64'(v.ar_len[s]));
            if (s == 0) begin
                chk("arsize", 64'(axi.arsize), 64'(6));
                chk("arburst", 64'(axi.arburst), 64'(1));
                chk("arcache", 64'(axi.arcache), 64'(3));
            end
            for (int d = 0; d < int'(v.ar_delay); d++) begin
                step();
                chk("stall_arvalid", 64'(axi.arvalid), 64'(1));
                chk("stall_araddr", 64'(axi.araddr), 64'(v.ar_addr[s]));
            end
            axi.arready = 1'b1;
            step();
            axi.arready = 1'b0;
            chk("arvalid_drop", 64'(axi.arvalid), 64'(0));
            chk("rready", 64'(axi.rready), 64'(1));
            for (int b = 0; b <= int'(v.ar_len[s]); b++) begin
                axi.rvalid = 1'b1;
                axi.rdata  = pat(vi, k);
                axi.rlast  = (b == int'(v.ar_len[s]));
                axi.rresp  = 2'b00;
                if (v.bad_kind == 2'd1 && k == int'(v.bad_beat)) axi.rresp = 2'b10;
                if (v.bad_kind == 2'd2 && k == int'(v.bad_beat)) axi.rlast = 1'b1;
                if (v.mid_en && k == 0) begin
                    dram_read_en   = 1'b1;
                    dram_read_addr = 39'h7_0000;
                    dram_read_len  = 8'd0;
                end
                step();
                axi.rvalid   = 1'b0;
                axi.rlast    = 1'b0;
                axi.rresp    = 2'b00;
                dram_read_en = 1'b0;
                chk("data_valid", 64'(dram_read_data_valid), 64'(1));
                chk_data("data", dram_read_data, pat(vi, k));
                k++;
                chk("busy", 64'(dram_read_busy), (k == total) ? 64'(0) : 64'(1));
                for (int g = 0; g < int'(v.gap); g++) begin
                    step();
                    chk("gap_valid", 64'(dram_read_data_valid), 64'(0));
                end
            end
        end
        chk("idle_arvalid", 64'(axi.arvalid), 64'(0));
        chk("idle_rready", 64'(axi.rready), 64'(0));
        chk("error", 64'(dram_read_error), 64'(v.exp_err));
    endtask

    initial begin
        #400000;
        n_vec++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        finish_run();
    end

    initial begin
        vecs[0] = mk(0, 39'h1000, 8'd0,   1, 39'h1000, 8'd0,  39'h0, 8'd0,
                     39'h0, 8'd0, 39'h0, 8'd0, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(0, 39'h0FC0, 8'd3,   2, 39'h0FC0, 8'd0,  39'h1000, 8'd2,
                     39'h0, 8'd0, 39'h0, 8'd0, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk(0, 39'h0000, 8'd255, 4, 39'h0000, 8'd63, 39'h1000, 8'd63,
                     39'h2000, 8'd63, 39'h3000, 8'd63, 0, 0, 0, 0, 0, 0);
        vecs[3] = mk(0, 39'h1025, 8'd0,   1, 39'h1000, 8'd0,  39'h0, 8'd0,
                     39'h0, 8'd0, 39'h0, 8'd0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(0, 39'h0F80, 8'd130, 4, 39'h0F80, 8'd1,  39'h1000, 8'd63,
                     39'h2000, 8'd63, 39'h3000, 8'd0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(0, 39'h2040, 8'd1,   1, 39'h2040, 8'd1,  39'h0, 8'd0,
                     39'h0, 8'd0, 39'h0, 8'd0, 5, 2, 1, 0, 0, 0);
        vecs[6] = mk(0, 39'h3000, 8'd3,   1, 39'h3000, 8'd3,  39'h0, 8'd0,
                     39'h0, 8'd0, 39'h0, 8'd0, 0, 0, 0, 1, 1, 1);
        vecs[7] = mk(1, 39'h4000, 8'd1,   1, 39'h4000, 8'd1,  39'h0, 8'd0,
                     39'h0, 8'd0, 39'h0, 8'd0, 0, 0, 0, 2, 0, 1);
        vecs[8] = mk(1, 39'h5FC0, 8'd1,   2, 39'h5FC0, 8'd0,  39'h6000, 8'd0,
                     39'h0, 8'd0, 39'h0, 8'd0, 0, 1, 0, 0, 0, 0);

        dram_reader_resetn = 1'b0;
        dram_read_en       = 1'b0;
        dram_read_addr     = '0;
        dram_read_len      = '0;
        axi.arready        = 1'b0;
        axi.rdata          = '0;
        axi.rresp          = 2'b00;
        axi.rlast          = 1'b0;
        axi.rvalid         = 1'b0;
        #12;
        chk("rst_busy", 64'(dram_read_busy), 64'(0));
        chk("rst_valid", 64'(dram_read_data_valid), 64'(0));
        chk_data("rst_data", dram_read_data, '0);
        chk("rst_error", 64'(dram_read_error), 64'(0));
        chk("rst_arvalid", 64'(axi.arvalid), 64'(0));
        chk("rst_araddr", 64'(axi.araddr), 64'(0));
        chk("rst_arlen", 64'(axi.arlen), 64'(0));
        chk("rst_rready", 64'(axi.rready), 64'(0));
        step();
        dram_reader_resetn = 1'b1;
        step();

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Reset mid-burst, between clock edges, with error and valid both high.
        dram_read_en   = 1'b1;
        dram_read_addr = 39'h7000;
        dram_read_len  = 8'd3;
        step();
        dram_read_en = 1'b0;
        wait_ar();
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = pat(15, 0);
        axi.rresp   = 2'b10;
        step();
        axi.rvalid = 1'b0;
        axi.rresp  = 2'b00;
        chk("pre_rst_valid", 64'(dram_read_data_valid), 64'(1));
        chk("pre_rst_error", 64'(dram_read_error), 64'(1));
        #2;
        dram_reader_resetn = 1'b0;
        #1;
        chk("async_busy", 64'(dram_read_busy), 64'(0));
        chk("async_valid", 64'(dram_read_data_valid), 64'(0));
        chk("async_error", 64'(dram_read_error), 64'(0));
        chk("async_arvalid", 64'(axi.arvalid), 64'(0));
        chk("async_rready", 64'(axi.rready), 64'(0));
        chk_data("async_data", dram_read_data, '0);
        step();
        dram_reader_resetn = 1'b1;
        step();
        run_vec(mk(0, 39'h8000, 8'd0, 1, 39'h8000, 8'd0, 39'h0, 8'd0,
                   39'h0, 8'd0, 39'h0, 8'd0, 0, 0, 0, 0, 0, 0), 14);

        finish_run();
    end

endmodule
